// File: rtl/lenet_predict_mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package : lenet_predict_pkg
// Brief   : Shared defaults for the LeNet predict multiplier arbiter slice.
// Rev     : 1.0 - initial release
// ============================================================================
package lenet_predict_pkg;

  localparam int c_NUM_REQ    = 4;
  localparam int c_DIN0_WIDTH = 3;
  localparam int c_DIN1_WIDTH = 11;
  localparam int c_DOUT_WIDTH = 13;
  localparam int c_OP_CNT_W   = 16;

endpackage : lenet_predict_pkg
`default_nettype wire

// File: rtl/lenet_predict_mul_arb_if.sv
`default_nettype none
// ============================================================================
// Interface : lenet_predict_mul_arb_if
// Brief     : Request/response bundle between requesters and the shared
//             multiplier arbiter.
// Rev       : 1.0 - initial release
// ============================================================================
interface lenet_predict_mul_arb_if
  import lenet_predict_pkg::*;
#(
  parameter int NUM_REQ    = c_NUM_REQ,
  parameter int DIN0_WIDTH = c_DIN0_WIDTH,
  parameter int DIN1_WIDTH = c_DIN1_WIDTH,
  parameter int DOUT_WIDTH = c_DOUT_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [$clog2(NUM_REQ)-1:0]    rsp_id;
  logic [DOUT_WIDTH-1:0]         rsp_dout;
  logic [c_OP_CNT_W-1:0]         op_count;

  // Requester/consumer side
  modport master (
    output req_valid, req_din0, req_din1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_dout, op_count
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_din0, req_din1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_dout, op_count
  );

endinterface : lenet_predict_mul_arb_if
`default_nettype wire

// File: rtl/lenet_predict_mul_arb_mul.sv
`default_nettype none
// ============================================================================
// Module : lenet_predict_mul_3ns_11ns_13_1_1
// Brief  : Combinational unsigned multiplier, product truncated to DOUT_WIDTH.
// Rev    : 1.0 - initial release
// ============================================================================
module lenet_predict_mul_3ns_11ns_13_1_1
  import lenet_predict_pkg::*;
#(
  parameter int DIN0_WIDTH = c_DIN0_WIDTH,
  parameter int DIN1_WIDTH = c_DIN1_WIDTH,
  parameter int DOUT_WIDTH = c_DOUT_WIDTH
)
(
  input  wire logic [DIN0_WIDTH-1:0] i_din0,
  input  wire logic [DIN1_WIDTH-1:0] i_din1,
  output logic      [DOUT_WIDTH-1:0] o_dout
);

  // Full product width wide enough for both the exact result and the output
  localparam int c_PW = (DIN0_WIDTH + DIN1_WIDTH > DOUT_WIDTH) ?
                        (DIN0_WIDTH + DIN1_WIDTH) : DOUT_WIDTH;

  // Zero-extend both operands, multiply, keep the low DOUT_WIDTH bits
  assign o_dout = DOUT_WIDTH'(c_PW'(i_din0) * c_PW'(i_din1));

endmodule : lenet_predict_mul_3ns_11ns_13_1_1
`default_nettype wire

// File: rtl/lenet_predict_mul_arb.sv
`default_nettype none
// ============================================================================
// Module : lenet_predict_mul_arb
// Brief  : Round-robin arbiter sharing one multiplier among NUM_REQ
//          requesters, with a single registered result stage.
// Rev    : 1.0 - initial release
// ============================================================================
module lenet_predict_mul_arb
  import lenet_predict_pkg::*;
#(
  parameter int NUM_REQ    = c_NUM_REQ,
  parameter int DIN0_WIDTH = c_DIN0_WIDTH,
  parameter int DIN1_WIDTH = c_DIN1_WIDTH,
  parameter int DOUT_WIDTH = c_DOUT_WIDTH
)
(
  input  wire logic              ap_clk,
  input  wire logic              ap_rst,
  lenet_predict_mul_arb_if.slave bus
);

  localparam int c_ID_W = $clog2(NUM_REQ);

  logic                  r_rsp_valid;
  logic [c_ID_W-1:0]     r_rsp_id;
  logic [DOUT_WIDTH-1:0] r_rsp_dout;
  logic [c_ID_W-1:0]     r_rr_ptr;
  logic [c_OP_CNT_W-1:0] r_op_count;

  logic                  w_can_issue;
  logic                  w_rsp_xfer;
  logic                  w_found;
  logic [c_ID_W-1:0]     w_gnt_id;
  logic [c_ID_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]    w_ready;
  logic [DIN0_WIDTH-1:0] w_din0;
  logic [DIN1_WIDTH-1:0] w_din1;
  logic [DOUT_WIDTH-1:0] w_prod;
  logic [DIN0_WIDTH-1:0] w_a [NUM_REQ];
  logic [DIN1_WIDTH-1:0] w_b [NUM_REQ];

  // Split the flat operand buses into per-requester slices
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a[gi] = bus.req_din0[gi*DIN0_WIDTH +: DIN0_WIDTH];
    assign w_b[gi] = bus.req_din1[gi*DIN1_WIDTH +: DIN1_WIDTH];
  end

  // The result register can take a new product when empty or being drained
  assign w_rsp_xfer  = r_rsp_valid && bus.rsp_ready;
  assign w_can_issue = !r_rsp_valid || bus.rsp_ready;

  // Round-robin search: first valid requester at or after r_rr_ptr
  always_comb begin
    int            w_idx;
    logic [c_ID_W-1:0] w_sel;
    w_found   = 1'b0;
    w_gnt_id  = '0;
    w_ptr_nxt = r_rr_ptr;
    w_ready   = '0;
    w_din0    = '0;
    w_din1    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      w_sel = c_ID_W'(w_idx);
      if (!w_found && w_can_issue && !ap_rst && bus.req_valid[w_sel]) begin
        w_found        = 1'b1;
        w_gnt_id       = w_sel;
        w_ptr_nxt      = c_ID_W'((w_idx + 1) % NUM_REQ);
        w_ready[w_sel] = 1'b1;
        w_din0         = w_a[w_sel];
        w_din1         = w_b[w_sel];
      end
    end
  end

  lenet_predict_mul_3ns_11ns_13_1_1 #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_mul (
    .i_din0 (w_din0),
    .i_din1 (w_din1),
    .o_dout (w_prod)
  );

  // Result register, round-robin pointer and saturating completion counter
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_dout  <= '0;
      r_rr_ptr    <= '0;
      r_op_count  <= '0;
    end else begin
      if (w_found) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_gnt_id;
        r_rsp_dout  <= w_prod;
        r_rr_ptr    <= w_ptr_nxt;
      end else if (w_rsp_xfer) begin
        r_rsp_valid <= 1'b0;
      end
      if (w_rsp_xfer && (r_op_count != {c_OP_CNT_W{1'b1}})) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_dout  = r_rsp_dout;
  assign bus.op_count  = r_op_count;

endmodule : lenet_predict_mul_arb
`default_nettype wire

// File: tb/tb_lenet_predict_mul_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_lenet_predict_mul_arb
// Brief  : Self-checking bench for lenet_predict_mul_arb (default params).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lenet_predict_mul_arb;

  localparam int N    = 4;
  localparam int MODV = 8192;

  logic ap_clk;
  logic ap_rst;

  lenet_predict_mul_arb_if bus ();

  lenet_predict_mul_arb u_dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: the result register contents, pointer, counter
  int m_valid = 0;
  int m_id    = 0;
  int m_dout  = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  logic [3:0] obs_ready;

  typedef struct {
    int id;
    int a;
    int b;
    int exp_dout;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Lowest valid index >= ptr, else lowest valid index overall, else -1
  function automatic int pick(input logic [3:0] v, input int ptr);
    int best;
    best = -1;
    for (int i = 0; i < N; i++)
      if (((v >> i) & 4'd1) != 4'd0 && i >= ptr && best < 0) best = i;
    for (int i = 0; i < N; i++)
      if (((v >> i) & 4'd1) != 4'd0 && best < 0) best = i;
    return best;
  endfunction

  // One clock cycle: drive, check against model, clock, advance model
  task automatic step(input logic rst, input logic [3:0] v, input logic [11:0] d0,
                      input logic [43:0] d1, input logic rr);
    int   g;
    int   a;
    int   b;
    logic xfer;
    ap_rst        = rst;
    bus.req_valid = v;
    bus.req_din0  = d0;
    bus.req_din1  = d1;
    bus.rsp_ready = rr;
    #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
    chk("rsp_id",    32'(bus.rsp_id),    32'(m_id));
    chk("rsp_dout",  32'(bus.rsp_dout),  32'(m_dout));
    chk("op_count",  32'(bus.op_count),  32'(m_cnt));
    g = (rst || (m_valid != 0 && !rr)) ? -1 : pick(v, m_ptr);
    chk("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
    obs_ready = bus.req_ready;
    xfer = (m_valid != 0) && rr;
    a = (g < 0) ? 0 : int'((d0 >> (3 * g)) & 12'h7);
    b = (g < 0) ? 0 : int'((d1 >> (11 * g)) & 44'h7FF);
    @(posedge ap_clk);
    if (rst) begin
      m_valid = 0; m_id = 0; m_dout = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (xfer && m_cnt < 65535) m_cnt++;
      if (g >= 0) begin
        m_valid = 1;
        m_id    = g;
        m_dout  = (a * b) % MODV;
        m_ptr   = (g + 1) % N;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  initial begin
    int          exp_g [5];
    int          h_id;
    int          h_dout;
    logic [11:0] d0;
    logic [43:0] d1;

    tbl[0] = '{0, 5, 1000, 5000};
    tbl[1] = '{1, 7, 2047, 6137};
    tbl[2] = '{2, 0, 1234, 0};
    tbl[3] = '{3, 1, 2047, 2047};
    tbl[4] = '{2, 4, 2047, 8188};
    tbl[5] = '{1, 6, 1500, 808};
    tbl[6] = '{3, 7, 1171, 5};
    exp_g  = '{0, 1, 2, 3, 0};

    ap_rst        = 1'b1;
    bus.req_valid = '0;
    bus.req_din0  = '0;
    bus.req_din1  = '0;
    bus.rsp_ready = 1'b0;
    @(posedge ap_clk);
    #1;

    // Reset state, with requests pending during reset
    step(1'b1, 4'hF, 12'hFFF, 44'hFFFFFFFFFFF, 1'b1);
    chk("rst_ready", 32'(obs_ready), 32'd0);
    chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_count", 32'(bus.op_count), 32'd0);

    // Single-request product table
    for (int i = 0; i < 7; i++) begin
      d0 = 12'(tbl[i].a) << (3 * tbl[i].id);
      d1 = 44'(tbl[i].b) << (11 * tbl[i].id);
      step(1'b0, 4'(1 << tbl[i].id), d0, d1, 1'b1);
      chk("tbl_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tbl_id",    32'(bus.rsp_id),    32'(tbl[i].id));
      chk("tbl_dout",  32'(bus.rsp_dout),  32'(tbl[i].exp_dout));
      chk("tbl_cnt",   32'(bus.op_count),  32'(i));
    end
    step(1'b0, 4'h0, 12'h0, 44'h0, 1'b1);
    chk("tbl_final_cnt", 32'(bus.op_count), 32'd7);
    chk("tbl_drained",   32'(bus.rsp_valid), 32'd0);

    // Contention from reset: grants 0,1,2,3,0 with one result per cycle
    step(1'b1, 4'h0, 12'h0, 44'h0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 4'hF, 12'hFAC, 44'h123456789AB, 1'b1);
      chk("cont_ready", 32'(obs_ready), 32'(1 << exp_g[j]));
      chk("cont_valid", 32'(bus.rsp_valid), 32'd1);
      chk("cont_id",    32'(bus.rsp_id), 32'(exp_g[j]));
    end

    // Backpressure: three stalled cycles hold the result, then pointer=1 wins
    h_id   = int'(bus.rsp_id);
    h_dout = int'(bus.rsp_dout);
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 4'hF, 12'hFAC, 44'h123456789AB, 1'b0);
      chk("bp_ready", 32'(obs_ready), 32'd0);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_id",    32'(bus.rsp_id), 32'(h_id));
      chk("bp_dout",  32'(bus.rsp_dout), 32'(h_dout));
    end
    step(1'b0, 4'hF, 12'hFAC, 44'h123456789AB, 1'b1);
    chk("bp_release", 32'(obs_ready), 32'd2);

    // Round-robin fairness with pointer at 2 and requesters 0 and 3 valid
    step(1'b1, 4'h0, 12'h0, 44'h0, 1'b0);
    step(1'b0, 4'b0010, 12'h0, 44'h0, 1'b1);
    step(1'b0, 4'b1001, 12'h0, 44'h0, 1'b1);
    chk("rr_first", 32'(obs_ready), 32'd8);
    step(1'b0, 4'b1001, 12'h0, 44'h0, 1'b1);
    chk("rr_second", 32'(obs_ready), 32'd1);

    // Reset while a result is pending discards it
    chk("mid_pre_valid", 32'(bus.rsp_valid), 32'd1);
    step(1'b1, 4'hF, 12'h0, 44'h0, 1'b0);
    chk("mid_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_count", 32'(bus.op_count), 32'd0);
    step(1'b0, 4'hF, 12'h0, 44'h0, 1'b1);
    chk("mid_first", 32'(obs_ready), 32'd1);

    // Randomized traffic against the model
    for (int j = 0; j < 400; j++) begin
      step(($urandom_range(0, 39) == 0), 4'($urandom()), 12'($urandom()),
           44'({$urandom(), $urandom()}), ($urandom_range(0, 3) != 0));
    end
    step(1'b0, 4'h0, 12'h0, 44'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lenet_predict_mul_arb
`default_nettype wire

// File: doc/lenet_predict_mul_arb.md
LENET_PREDICT_MUL_ARB -- requirements
Module: lenet_predict_mul_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DIN0_WIDTH, default 3, unsigned operand A width.
REQ-003 SHALL have parameter DIN1_WIDTH, default 11, unsigned operand B width.
REQ-004 SHALL have parameter DOUT_WIDTH, default 13, product width.
REQ-005 SHALL have port ap_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port ap_rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port req_valid, input, NUM_REQ, per-requester operand valid.
REQ-008 SHALL have port req_ready, output, NUM_REQ, per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_din0, input, NUM_REQ*DIN0_WIDTH, operand A; requester i occupies slice i.
REQ-010 SHALL have port req_din1, input, NUM_REQ*DIN1_WIDTH, operand B; requester i occupies slice i.
REQ-011 SHALL have port rsp_valid, output, 1, result register holds a valid product.
REQ-012 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-013 SHALL have port rsp_id, output, clog2(NUM_REQ), index of the requester owning the result.
REQ-014 SHALL have port rsp_dout, output, DOUT_WIDTH, product.
REQ-015 SHALL have port op_count, output, 16, saturating count of completed multiplies.

Function
REQ-016 SHALL define transfer on a request as req_valid[i] && req_ready[i], and on a response as rsp_valid && rsp_ready.
REQ-017 SHALL set can_issue = !rsp_valid || rsp_ready; req_ready SHALL be all-zero when can_issue is 0.
REQ-018 SHALL, when can_issue is 1, grant at most one requester per cycle by round-robin: the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-019 SHALL, on grant of index g, update rr_ptr to (g+1) mod NUM_REQ; rr_ptr SHALL be unchanged when nothing is granted.
REQ-020 SHALL drive req_ready combinationally from req_valid, rr_ptr and can_issue; a requester whose valid is low is never granted.
REQ-021 SHALL multiply the granted operands as unsigned values, zero-extended, and keep the low DOUT_WIDTH bits (product mod 2^DOUT_WIDTH).
REQ-022 SHALL register the product, the granted index and rsp_valid=1 at the edge of the granting cycle: latency is exactly 1 cycle from request transfer to rsp_valid.
REQ-023 SHALL clear rsp_valid after a response transfer with no simultaneous grant; a simultaneous grant SHALL reload the register, giving one result per cycle at full throughput.
REQ-024 SHALL hold rsp_valid, rsp_id and rsp_dout stable while rsp_valid && !rsp_ready.
REQ-025 SHALL increment op_count on each response transfer and saturate at 16'hFFFF.
REQ-026 SHALL tolerate requesters dropping req_valid without a transfer; no state changes result.

Reset
REQ-027 SHALL, while ap_rst is 1 at a clock edge, set rsp_valid=0, rsp_id=0, rsp_dout=0, rr_ptr=0 and op_count=0, and drive req_ready all-zero during that cycle.
REQ-028 SHALL discard any in-flight result on reset mid-operation; no response for it SHALL appear after reset.

Structure
REQ-029 SHALL place the shared parameter defaults (widths, NUM_REQ) and the op_count width constant in package lenet_predict_pkg.
REQ-030 SHALL instantiate exactly one lenet_predict_mul_3ns_11ns_13_1_1 as the combinational multiplier; the arbiter SHALL contain no other multiplier.

Verification
REQ-031 SHALL cover single request: req0 din0=5, din1=1000 -> next cycle rsp_valid=1, rsp_id=0, rsp_dout=5000; op_count=1 after rsp_ready.
REQ-032 SHALL cover wrap: din0=7, din1=2047 -> rsp_dout=6137 (14329 mod 8192).
REQ-033 SHALL cover contention: all 4 valid continuously from reset with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles and one result per cycle.
REQ-034 SHALL cover backpressure: rsp_ready=0 for 3 cycles with result held -> rsp outputs stable, req_ready=0 for those cycles, then a grant in the cycle rsp_ready returns to 1.
REQ-035 SHALL cover round-robin fairness: rr_ptr=2 with req0 and req3 valid -> req3 granted first, then req0.
REQ-036 SHALL cover reset mid-operation: assert ap_rst while rsp_valid=1 -> next cycle rsp_valid=0, op_count=0, first grant afterwards goes to req0.
